// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM encoding and width helpers
// for the UART transmit arbiter (no ports; imported by rtl/).
package uart_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Bits to hold 0..max_val, never below one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits to index n ports, never below one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set bit of req_i scanning from ptr_i upward
// (mod N). Ports: req_i, ptr_i in; grant_id_o, grant_any_o out.
module rr_priority_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] grant_id_o,
  output logic          grant_any_o
);

  logic [IW-1:0] idx;

  always_comb begin
    grant_any_o = 1'b0;
    grant_id_o  = '0;
    idx         = '0;
    // Walk from the far end so the port nearest ptr wins last.
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_i) + k) % N);
      if (req_i[idx]) begin
        grant_any_o = 1'b1;
        grant_id_o  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-granular round-robin sharing of one UART tx.
// Ports: req_* per-port byte streams, tx_* to transmitter, grant_* status.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int N_PORTS        = 2,
  parameter  int MAX_BURST      = 64,
  parameter  int TIMEOUT_CYCLES = 0,
  localparam int PW             = idx_width(N_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8*N_PORTS-1:0] req_data,
  input  logic [N_PORTS-1:0]   req_valid,
  input  logic [N_PORTS-1:0]   req_last,
  output logic [N_PORTS-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 grant_valid,
  output logic [PW-1:0]        grant_id
);

  localparam int BW = cnt_width(MAX_BURST);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [BW-1:0] BURST_LAST =
    BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] IDLE_LAST =
    TW'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [PW-1:0] PORT_LAST =
    PW'(N_PORTS - 1);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;

  logic [PW-1:0] pick_id;
  logic          pick_any;
  logic          locked;
  logic          own_valid;
  logic          own_last;
  logic          xfer;
  logic          release_msg;
  logic [PW-1:0] owner_inc;
  logic [7:0]    port_byte [N_PORTS];

  for (genvar g = 0; g < N_PORTS; g++) begin : g_byte
    assign port_byte[g] = req_data[8*g +: 8];
  end

  rr_priority_picker #(
    .N (N_PORTS)
  ) u_pick (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .grant_id_o  (pick_id),
    .grant_any_o (pick_any)
  );

  assign locked    = (state_q == ST_LOCKED);
  assign own_valid = req_valid[owner_q];
  assign own_last  = req_last[owner_q];
  assign xfer      = locked & own_valid & tx_ready;

  // Explicit wrap keeps non-power-of-two port counts in range.
  assign owner_inc = (owner_q == PORT_LAST) ?
                     '0 : owner_q + PW'(1);

  assign tx_valid    = locked & own_valid;
  assign tx_data     = tx_valid ? port_byte[owner_q] : '0;
  assign grant_valid = locked;
  assign grant_id    = owner_q;

  always_comb begin
    req_ready = '0;
    if (locked) req_ready[owner_q] = tx_ready;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    release_msg = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d = pick_id;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          burst_cnt_d = burst_cnt_q + BW'(1);
          idle_cnt_d  = '0;
          release_msg = own_last |
                        (burst_cnt_q == BURST_LAST);
        end else if (!own_valid && TIMEOUT_EN) begin
          // A stalled transmitter is not owner idleness.
          idle_cnt_d  = idle_cnt_q + TW'(1);
          release_msg = (idle_cnt_q == IDLE_LAST);
        end
        if (release_msg) begin
          state_d     = ST_IDLE;
          rr_ptr_d    = owner_inc;
          burst_cnt_d = '0;
          idle_cnt_d  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table, directed corner sequences and
// randomized traffic against a behavioural arbiter model.
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int MB = 4;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req_data;
  logic [1:0]  req_valid;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        grant_valid;
  logic [0:0]  grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_PORTS        (N),
    .MAX_BURST      (MB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_data    (req_data),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  int    n_vec = 0;
  int    n_bad = 0;
  string sec   = "init";

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h, want %0h",
               sec, nm, act, exp);
    end
  endtask

  // Behavioural model: who owns the line, where the scan starts,
  // bytes sent in this grant and consecutive owner-silent cycles.
  bit m_lk;
  int m_own, m_rr, m_sent, m_idle;

  task automatic m_release();
    m_lk   = 1'b0;
    m_rr   = (m_own + 1) % N;
    m_sent = 0;
    m_idle = 0;
  endtask

  task automatic model_step();
    bit found;
    int p;
    found = 1'b0;
    p     = 0;
    if (reset) begin
      m_lk = 1'b0; m_own = 0; m_rr = 0;
      m_sent = 0;  m_idle = 0;
    end else if (!m_lk) begin
      for (int k = 0; k < N; k++) begin
        p = (m_rr + k) % N;
        if (!found && req_valid[p]) begin
          found = 1'b1;
          m_own = p;
          m_lk  = 1'b1;
        end
      end
    end else if (req_valid[m_own]) begin
      if (tx_ready) begin
        m_sent++;
        m_idle = 0;
        if (req_last[m_own] || m_sent == MB) m_release();
      end
    end else begin
      m_idle++;
      if (TO != 0 && m_idle == TO) m_release();
    end
  endtask

  task automatic model_check(output logic [1:0] er);
    logic       ev;
    logic [7:0] ed;
    er = '0;
    ev = 1'b0;
    ed = '0;
    if (m_lk) begin
      ev = req_valid[m_own];
      ed = ev ? req_data[8*m_own +: 8] : 8'h00;
      er[m_own] = tx_ready;
    end
    chk("tx_valid", 32'(tx_valid), 32'(ev));
    chk("tx_data", 32'(tx_data), 32'(ed));
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("grant_valid", 32'(grant_valid), 32'(m_lk));
    chk("grant_id", 32'(grant_id), m_own);
  endtask

  // Byte sources and accepted-byte log.
  logic [7:0] q_d [2][$];
  logic       q_l [2][$];
  logic [7:0] tx_log [$];
  bit         en [2];

  task automatic drv_cycle(input logic [1:0] gate,
                           input logic tr,
                           input logic rst,
                           output logic acc);
    logic [1:0] er;
    acc      = 1'b0;
    reset    = rst;
    tx_ready = tr;
    for (int i = 0; i < N; i++) begin
      if (en[i] && gate[i] && q_d[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = q_d[i][0];
        req_last[i]         = q_l[i][0];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'($urandom);
        req_last[i]         = 1'($urandom);
      end
    end
    @(negedge clk);
    model_check(er);
    for (int i = 0; i < N; i++) begin
      if (!rst && req_valid[i] && er[i]) begin
        tx_log.push_back(q_d[i][0]);
        void'(q_d[i].pop_front());
        void'(q_l[i].pop_front());
        acc = 1'b1;
      end
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_section(input string nm);
    logic a;
    sec = nm;
    for (int i = 0; i < N; i++) begin
      q_d[i].delete();
      q_l[i].delete();
      en[i] = 1'b0;
    end
    drv_cycle(2'b00, 1'b1, 1'b1, a);
    drv_cycle(2'b00, 1'b1, 1'b1, a);
    tx_log.delete();
  endtask

  task automatic push(input int p, input logic [7:0] d,
                      input logic l);
    q_d[p].push_back(d);
    q_l[p].push_back(l);
  endtask

  task automatic chk_log(input string nm,
                         input logic [7:0] want [$]);
    chk({nm, ".len"}, 32'(tx_log.size()), 32'(want.size()));
    for (int k = 0; k < want.size(); k++)
      if (k < tx_log.size())
        chk($sformatf("%s[%0d]", nm, k),
            32'(tx_log[k]), 32'(want[k]));
  endtask

  // Vector table: inputs for one cycle and the outputs required in it.
  typedef struct {
    logic       rst;
    logic [1:0] v;
    logic [1:0] l;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       tr;
    logic       etv;
    logic [7:0] etd;
    logic [1:0] erd;
    logic       egv;
    logic       egid;
  } vec_t;

  localparam int NV = 22;
  vec_t tv [NV];

  function automatic vec_t mk(
    logic rst, logic [1:0] v, logic [1:0] l,
    logic [7:0] d0, logic [7:0] d1, logic tr,
    logic etv, logic [7:0] etd, logic [1:0] erd,
    logic egv, logic egid);
    vec_t r;
    r.rst = rst; r.v = v; r.l = l; r.d0 = d0; r.d1 = d1;
    r.tr = tr; r.etv = etv; r.etd = etd; r.erd = erd;
    r.egv = egv; r.egid = egid;
    return r;
  endfunction

  task automatic run_table();
    sec = "table";
    tv[0]  = mk(1'b1, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1,
                1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    tv[1]  = mk(1'b0, 2'b01, 2'b01, 8'h41, 8'h00, 1'b1,
                1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    tv[2]  = mk(1'b0, 2'b01, 2'b01, 8'h41, 8'h00, 1'b1,
                1'b1, 8'h41, 2'b01, 1'b1, 1'b0);
    tv[3]  = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1,
                1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    tv[4]  = mk(1'b1, 2'b11, 2'b00, 8'h41, 8'h43, 1'b1,
                1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    tv[5]  = mk(1'b0, 2'b11, 2'b00, 8'h41, 8'h43, 1'b1,
                1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    tv[6]  = mk(1'b0, 2'b11, 2'b00, 8'h41, 8'h43, 1'b1,
                1'b1, 8'h41, 2'b01, 1'b1, 1'b0);
    tv[7]  = mk(1'b0, 2'b11, 2'b01, 8'h42, 8'h43, 1'b1,
                1'b1, 8'h42, 2'b01, 1'b1, 1'b0);
    tv[8]  = mk(1'b0, 2'b10, 2'b10, 8'h00, 8'h43, 1'b1,
                1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    tv[9]  = mk(1'b0, 2'b10, 2'b10, 8'h00, 8'h43, 1'b1,
                1'b1, 8'h43, 2'b10, 1'b1, 1'b1);
    tv[10] = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1,
                1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
    tv[11] = mk(1'b0, 2'b01, 2'b00, 8'h55, 8'h00, 1'b0,
                1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
    tv[12] = mk(1'b0, 2'b01, 2'b00, 8'h55, 8'h00, 1'b0,
                1'b1, 8'h55, 2'b00, 1'b1, 1'b0);
    tv[13] = mk(1'b0, 2'b11, 2'b00, 8'h55, 8'h66, 1'b0,
                1'b1, 8'h55, 2'b00, 1'b1, 1'b0);
    tv[14] = mk(1'b0, 2'b11, 2'b01, 8'h55, 8'h66, 1'b1,
                1'b1, 8'h55, 2'b01, 1'b1, 1'b0);
    tv[15] = mk(1'b0, 2'b11, 2'b10, 8'h55, 8'h66, 1'b1,
                1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    tv[16] = mk(1'b0, 2'b11, 2'b10, 8'h55, 8'h66, 1'b1,
                1'b1, 8'h66, 2'b10, 1'b1, 1'b1);
    tv[17] = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1,
                1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
    tv[18] = mk(1'b0, 2'b01, 2'b00, 8'h77, 8'h00, 1'b1,
                1'b0, 8'h00, 2'b00, 1'b0, 1'b1);
    tv[19] = mk(1'b0, 2'b00, 2'b00, 8'h77, 8'h00, 1'b1,
                1'b0, 8'h00, 2'b01, 1'b1, 1'b0);
    tv[20] = mk(1'b0, 2'b01, 2'b01, 8'h77, 8'h00, 1'b1,
                1'b1, 8'h77, 2'b01, 1'b1, 1'b0);
    tv[21] = mk(1'b0, 2'b00, 2'b00, 8'h00, 8'h00, 1'b1,
                1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < NV; k++) begin
      reset     = tv[k].rst;
      req_valid = tv[k].v;
      req_last  = tv[k].l;
      req_data  = {tv[k].d1, tv[k].d0};
      tx_ready  = tv[k].tr;
      @(negedge clk);
      chk($sformatf("v%0d.tx_valid", k),
          32'(tx_valid), 32'(tv[k].etv));
      chk($sformatf("v%0d.tx_data", k),
          32'(tx_data), 32'(tv[k].etd));
      chk($sformatf("v%0d.req_ready", k),
          32'(req_ready), 32'(tv[k].erd));
      chk($sformatf("v%0d.grant_valid", k),
          32'(grant_valid), 32'(tv[k].egv));
      chk($sformatf("v%0d.grant_id", k),
          32'(grant_id), 32'(tv[k].egid));
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_burst();
    logic a;
    int   c;
    start_section("burst");
    for (int b = 0; b < 6; b++)
      push(1, 8'(8'h10 + b), b == 5);
    push(0, 8'hA0, 1'b1);
    en[1] = 1'b1;
    c = 0;
    while ((q_d[0].size() + q_d[1].size()) > 0 && c < 60) begin
      en[0] = (c >= 2);
      drv_cycle(2'b11, 1'b1, 1'b0, a);
      c++;
    end
    chk("drained", 32'(q_d[0].size() + q_d[1].size()), 0);
    chk_log("order", '{8'h10, 8'h11, 8'h12, 8'h13,
                       8'hA0, 8'h14, 8'h15});
  endtask

  task automatic run_timeout();
    logic a;
    int   c;
    int   lk0;
    start_section("timeout");
    push(0, 8'hB0, 1'b0);
    push(1, 8'hC0, 1'b1);
    en[0] = 1'b1;
    en[1] = 1'b1;
    c   = 0;
    lk0 = 0;
    while (q_d[1].size() > 0 && c < 80) begin
      drv_cycle(2'b11, 1'b1, 1'b0, a);
      if (grant_valid && grant_id == 1'b0) lk0++;
      c++;
    end
    chk("port1_sent", 32'(q_d[1].size()), 0);
    chk("hold_cycles", lk0, 1 + TO);
    chk_log("order", '{8'hB0, 8'hC0});
  endtask

  task automatic run_backpressure();
    logic a;
    int   busy;
    int   c;
    start_section("backpressure");
    for (int b = 0; b < 3; b++) begin
      push(0, 8'(8'h20 + b), b == 2);
      push(1, 8'(8'h30 + b), b == 2);
    end
    en[0] = 1'b1;
    en[1] = 1'b1;
    busy  = 0;
    c     = 0;
    while ((q_d[0].size() + q_d[1].size()) > 0 && c < 9000) begin
      drv_cycle(2'b11, busy == 0, 1'b0, a);
      if (a) busy = 1085;
      else if (busy > 0) busy--;
      c++;
    end
    chk("drained", 32'(q_d[0].size() + q_d[1].size()), 0);
    chk_log("order", '{8'h20, 8'h21, 8'h22,
                       8'h30, 8'h31, 8'h32});
  endtask

  task automatic run_reset_mid();
    logic a;
    int   c;
    start_section("reset_mid");
    push(0, 8'hD1, 1'b0);
    push(0, 8'hD2, 1'b0);
    push(0, 8'hD3, 1'b1);
    en[0] = 1'b1;
    c = 0;
    while (tx_log.size() < 1 && c < 10) begin
      drv_cycle(2'b01, 1'b1, 1'b0, a);
      c++;
    end
    drv_cycle(2'b01, 1'b0, 1'b0, a);
    drv_cycle(2'b01, 1'b0, 1'b1, a);
    chk("gv_after_reset", 32'(grant_valid), 0);
    chk("tv_after_reset", 32'(tx_valid), 0);
    en[0] = 1'b0;
    for (int k = 0; k < 10; k++)
      drv_cycle(2'b01, 1'b1, 1'b0, a);
    chk_log("accepted", '{8'hD1});
  endtask

  task automatic run_random();
    logic       a;
    logic [1:0] gate;
    int         pz [2];
    int         len;
    logic       rst;
    start_section("random");
    en[0] = 1'b1;
    en[1] = 1'b1;
    pz[0] = 0;
    pz[1] = 0;
    for (int c = 0; c < 4000; c++) begin
      gate = '0;
      for (int i = 0; i < N; i++) begin
        if (q_d[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 7);
          for (int b = 0; b < len; b++)
            push(i, 8'($urandom),
                 (b == len - 1) && ($urandom_range(0, 7) != 0));
        end
        if (pz[i] > 0) begin
          pz[i]--;
        end else if ($urandom_range(0, 29) == 0) begin
          pz[i] = $urandom_range(1, 24);
        end else begin
          gate[i] = ($urandom_range(0, 3) != 0);
        end
      end
      rst = ($urandom_range(0, 499) == 0);
      drv_cycle(gate, $urandom_range(0, 3) != 0, rst, a);
    end
  endtask

  initial begin
    logic a;
    reset     = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    tx_ready  = 1'b1;
    m_lk = 1'b0; m_own = 0; m_rr = 0; m_sent = 0; m_idle = 0;
    en[0] = 1'b0;
    en[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run_table();
    run_burst();
    run_timeout();
    run_backpressure();
    run_reset_mid();
    run_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
